// File: rtl/l15_simple_transducer_if.sv
// Client-side load/store port of l15_simple_transducer: one request/response
// handshake pair carrying 8-byte loads and stores.
interface l15_simple_transducer_if;
  logic        req_val;
  logic        req_rdy;
  logic        req_we;
  logic        req_nc;
  logic [39:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_val;
  logic        resp_rdy;
  logic [63:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_val, req_we, req_nc, req_addr, req_wdata, resp_rdy,
    input  req_rdy, resp_val, resp_rdata, resp_error
  );

  modport slave (
    input  req_val, req_we, req_nc, req_addr, req_wdata, resp_rdy,
    output req_rdy, resp_val, resp_rdata, resp_error
  );
endinterface

// File: rtl/l15_simple_transducer.sv
// Single-outstanding 8-byte load/store client to L1.5 request/return bridge.
// Acks every return; unsolicited or mismatched returns are counted and dropped.
//
// state | meaning
// IDLE  | ready for a client request
// REQ   | request presented to L1.5, waiting for ack
// WAIT  | request accepted, waiting for matching LOAD_RET / ST_ACK
// RESP  | response presented to client, waiting for resp_rdy
module l15_simple_transducer #(
  parameter logic        THREAD_ID  = 1'b0,
  parameter int unsigned L15_DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  l15_simple_transducer_if.slave cli,
  output logic [15:0]           drop_count,

  output logic                  transducer_l15_val,
  output logic [4:0]            transducer_l15_rqtype,
  output logic                  transducer_l15_nc,
  output logic [2:0]            transducer_l15_size,
  output logic                  transducer_l15_threadid,
  output logic [39:0]           transducer_l15_address,
  output logic [63:0]           transducer_l15_data,
  output logic [3:0]            transducer_l15_amo_op,
  output logic                  transducer_l15_prefetch,
  output logic                  transducer_l15_invalidate_cacheline,
  output logic                  transducer_l15_blockstore,
  output logic                  transducer_l15_blockinitstore,
  output logic [1:0]            transducer_l15_l1rplway,
  output logic [63:0]           transducer_l15_data_next_entry,
  output logic [32:0]           transducer_l15_csm_data,
  output logic                  transducer_l15_req_ack,

  input  logic                  l15_transducer_ack,
  input  logic                  l15_transducer_header_ack,
  input  logic                  l15_transducer_val,
  input  logic [3:0]            l15_transducer_returntype,
  input  logic [1:0]            l15_transducer_error,
  input  logic [L15_DATA_W-1:0] l15_transducer_data
);

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [2:0] SIZE_8B  = 3'b011;
  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state;

  logic is_store;
  logic ret_match;
  logic ret_drop;
  logic unused_ok;

  assign transducer_l15_threadid             = THREAD_ID;
  assign transducer_l15_amo_op               = '0;
  assign transducer_l15_prefetch             = 1'b0;
  assign transducer_l15_invalidate_cacheline = 1'b0;
  assign transducer_l15_blockstore           = 1'b0;
  assign transducer_l15_blockinitstore       = 1'b0;
  assign transducer_l15_l1rplway             = '0;
  assign transducer_l15_data_next_entry      = '0;
  assign transducer_l15_csm_data             = '0;
  assign transducer_l15_req_ack              = l15_transducer_val;

  assign is_store  = (transducer_l15_rqtype == STORE_RQ);
  assign ret_match = (state == WAIT) && l15_transducer_val &&
                     (l15_transducer_returntype == (is_store ? ST_ACK : LOAD_RET));
  // Anything consumed that is not the awaited return is dropped, including in REQ.
  assign ret_drop  = l15_transducer_val && !ret_match;

  assign unused_ok = ^{l15_transducer_header_ack, cli.req_addr[2:0], l15_transducer_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      cli.req_rdy            <= 1'b1;
      cli.resp_val           <= 1'b0;
      cli.resp_rdata         <= '0;
      cli.resp_error         <= 1'b0;
      drop_count             <= '0;
      transducer_l15_val     <= 1'b0;
      transducer_l15_rqtype  <= '0;
      transducer_l15_nc      <= 1'b0;
      transducer_l15_size    <= '0;
      transducer_l15_address <= '0;
      transducer_l15_data    <= '0;
    end else begin
      if (ret_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      case (state)
        IDLE: if (cli.req_val) begin
          transducer_l15_rqtype  <= cli.req_we ? STORE_RQ : LOAD_RQ;
          transducer_l15_nc      <= cli.req_nc;
          transducer_l15_size    <= SIZE_8B;
          transducer_l15_address <= {cli.req_addr[39:3], 3'b000};
          transducer_l15_data    <= cli.req_wdata;
          transducer_l15_val     <= 1'b1;
          cli.req_rdy            <= 1'b0;
          state                  <= REQ;
        end
        REQ: if (l15_transducer_ack) begin
          transducer_l15_val <= 1'b0;
          state              <= WAIT;
        end
        WAIT: if (ret_match) begin
          // L1.5 returns the 16-byte line big-endian: the lower address word is in [127:64].
          if (is_store)                       cli.resp_rdata <= '0;
          else if (transducer_l15_address[3]) cli.resp_rdata <= l15_transducer_data[63:0];
          else                                cli.resp_rdata <= l15_transducer_data[127:64];
          cli.resp_error <= |l15_transducer_error;
          cli.resp_val   <= 1'b1;
          state          <= RESP;
        end
        RESP: if (cli.resp_rdy) begin
          cli.resp_val <= 1'b0;
          cli.req_rdy  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
